seg_scan_drv: RTL

SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_hex_decode.sv | 17 +
 rtl/seg_scan_drv.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================
// Package : seg_pkg
// Hex font table and segment bit positions for seven-segment drive.
// Rev     : 1.0
// ============================================================
package seg_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Entry n holds the a..g pattern for nibble value n (entry 15 listed first).
    localparam logic [15:0][6:0] SEG_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================
// Module : seg_hex_decode
// Combinational nibble to a..g segment decoder.
// Rev    : 1.0
// ============================================================
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_FONT[nibble_i];

endmodule
`default_nettype wire

// File: rtl/seg_scan_drv.sv
`default_nettype none
// ============================================================
// Module : seg_scan_drv
// Multiplexed seven-segment scan driver: double-buffered digits,
// leading-zero blanking and PWM brightness.  Rev : 1.0
// ============================================================
module seg_scan_drv
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int PRESCALE_BITS = 16,
    parameter int PWM_BITS      = 4
)(
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      OE,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic                      lzb,
    input  logic [PWM_BITS-1:0]       brightness,
    output logic [NUM_DIGITS-1:0]     drains,
    output logic [7:0]                leds,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [PRESCALE_BITS-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0]  pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]    pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0]  act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]    act_dp_q, act_dp_d;
    logic                     frame_done_q;
    logic [NUM_DIGITS-1:0]    drains_q, drains_d;
    logic [7:0]               leds_q, leds_d;

    logic                     tick;
    logic                     boundary;
    logic                     accept;
    logic [3:0]               nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]    blank;
    logic                     blank_run;
    logic [3:0]               cur_nib;
    logic [6:0]               cur_seg;
    logic [PWM_BITS-1:0]      duty;
    logic                     lit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi] = act_data_q[4*gi +: 4];
        end
    endgenerate

    assign tick       = &presc_q;
    assign boundary   = tick && (idx_q == LAST_IDX);
    assign data_ready = ~pend_q;
    assign accept     = data_valid && ~pend_q;

    always_comb begin
        presc_d     = presc_q + PRESCALE_BITS'(1);
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;

        if (tick) begin
            idx_d = boundary ? '0 : idx_q + IDX_W'(1);
        end

        // accept needs pend_q clear, so it can never race the transfer below.
        if (accept) begin
            pend_d      = 1'b1;
            pend_data_d = data;
            pend_dp_d   = dp;
        end else if (boundary && pend_q) begin
            pend_d     = 1'b0;
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
        end
    end

    // Blank from the top digit down while zero; digit 0 always shows.
    always_comb begin
        blank     = '0;
        blank_run = lzb;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            blank_run = blank_run && (nib[i] == 4'h0);
            blank[i]  = blank_run;
        end
    end

    assign cur_nib = nib[idx_q];

    seg_hex_decode u_hex_decode (
        .nibble_i (cur_nib),
        .seg_o    (cur_seg)
    );

    assign duty = presc_q[PRESCALE_BITS-1 -: PWM_BITS];
    assign lit  = OE && (duty < brightness);

    always_comb begin
        drains_d = '0;
        leds_d   = '0;
        if (lit) begin
            drains_d[idx_q]      = 1'b1;
            leds_d[SEG_G:SEG_A]  = blank[idx_q] ? 7'h00 : cur_seg;
            leds_d[SEG_DP]       = act_dp_q[idx_q];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            frame_done_q <= 1'b0;
            drains_q     <= '0;
            leds_q       <= '0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            frame_done_q <= boundary;
            drains_q     <= drains_d;
            leds_q       <= leds_d;
        end
    end

    assign drains     = drains_q;
    assign leds       = leds_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
